// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial WIDTH-bit adder/subtractor.
// A single one-bit full-add stage with a registered carry processes one
// operand bit per clock, LSB first. Subtraction is a + ~b + 1: operand B is
// inverted on load and the carry register is seeded with 1.
// Optional feature: define SERIAL_ADD_SUB_ZERO_FLAG_EN to add the 'zero'
// result flag output.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] MSB_CIN_BIT = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic             r_cmsb;
  logic             r_carry_out;
  logic             r_overflow;
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
  logic             r_zacc;
  logic             r_zero;
`endif

  logic             w_s;
  logic             w_cn;
  logic             w_accept;
  logic [WIDTH-1:0] w_acc_next;

  // One-bit full-add stage on the current LSBs of the operand shifters.
  assign w_s        = r_sa[0] ^ r_sb[0] ^ r_c;
  assign w_cn       = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_c) | (r_sb[0] & r_c);
  assign w_accept   = start & r_ready;
  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign w_acc_next = WIDTH'({w_s, r_acc} >> 1);

  // Control FSM, operand/result shifters and registered flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sa        <= '0;
      r_sb        <= '0;
      r_acc       <= '0;
      r_result    <= '0;
      r_cnt       <= '0;
      r_c         <= 1'b0;
      r_cmsb      <= 1'b0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
      r_zacc      <= 1'b0;
      r_zero      <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        // Accept from IDLE or back-to-back from DONE.
        r_state <= S_RUN;
        r_ready <= 1'b0;
        r_busy  <= 1'b1;
        r_sa    <= a;
        r_sb    <= b ^ {WIDTH{mode}};
        r_c     <= mode;
        r_cnt   <= '0;
        r_acc   <= '0;
        r_cmsb  <= 1'b0;
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
        r_zacc  <= 1'b0;
`endif
      end else begin
        case (r_state)
          S_RUN: begin
            r_sa  <= r_sa >> 1;
            r_sb  <= r_sb >> 1;
            r_acc <= w_acc_next;
            r_c   <= w_cn;
            r_cnt <= r_cnt + CW'(1);
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
            r_zacc <= r_zacc | w_s;
`endif
            // Carry into the MSB position, needed for signed overflow.
            if (r_cnt == MSB_CIN_BIT) begin
              r_cmsb <= w_cn;
            end
            if (r_cnt == LAST_BIT) begin
              r_result    <= w_acc_next;
              r_carry_out <= w_cn;
              r_overflow  <= r_cmsb ^ w_cn;
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
              r_zero      <= ~(r_zacc | w_s);
`endif
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_ready     <= 1'b1;
              r_busy      <= 1'b0;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          S_IDLE: begin
          end
          default: begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ready     = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
  assign zero      = r_zero;
`endif

endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Bit-serial WIDTH-bit adder/subtractor built around a single one-bit full-add stage and a registered carry.
- Processes one bit per clock, LSB first.
- Accepts operands through a start/ready handshake and pulses done when the result is valid.
- Serves as the area-minimal arithmetic stage between operand registers and the downstream result consumer, with no wide carry chain.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-high.
start  input  1  request to begin an operation; sampled only when ready=1.
mode  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
a  input  WIDTH  operand A; sampled with start.
b  input  WIDTH  operand B; sampled with start.
ready  output  1  block can accept start this cycle.
busy  output  1  operation in progress (state RUN).
done  output  1  one-cycle pulse: result/flags valid.
result  output  WIDTH  sum/difference; held until the next accepted start.
carry_out  output  1  final carry. Add: unsigned overflow. Sub: 1 = no borrow (a >= b unsigned).
overflow  output  1  signed two's-complement overflow.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, ready=1, busy=0, done=0, result=0, carry_out=0, overflow=0, internal shift registers/counter/carry all 0.
- States:
  - IDLE: ready=1. start=1 -> RUN.
  - RUN: ready=0, busy=1. After WIDTH bit-cycles -> DONE.
  - DONE: one cycle, done=1, ready=1. start=1 -> RUN (back-to-back); else -> IDLE.
- Accept (edge where start=1 and ready=1):
  - Load shift register SA <= a and SB <= b XOR {WIDTH{mode}}.
  - Carry register c <= mode.
  - Bit counter <= 0.
  - Clear the result shift register.
- Each RUN edge:
  - s = SA[0]^SB[0]^c; cnext = majority(SA[0],SB[0],c).
  - Shift SA and SB right by one. Shift s into the result register at the MSB, shifting it right.
  - c <= cnext. Counter increments.
  - On the edge processing bit WIDTH-2, capture cnext as the carry into the MSB (cmsb).
- Final RUN edge (counter = WIDTH-1):
  - Result register holds the full value.
  - carry_out <= cnext; overflow <= cmsb XOR cnext.
  - State -> DONE.
- Latency: accept at edge E0; done high in the cycle following edge E(WIDTH); WIDTH+1 cycles from start to done; throughput one op per WIDTH+1 cycles.
- result, carry_out and overflow update only on the final RUN edge. They are stable outside RUN and hold through IDLE.
- start while busy=1 is ignored; a, b and mode are don't-care during RUN.
- done is never asserted for more than one consecutive cycle. A back-to-back start in DONE still yields a 1-cycle done per operation.
- rst mid-RUN aborts:
  - All outputs return to reset values on that edge.
  - No done pulse for the aborted operation.
  - ready=1 in the following cycle.
- Arithmetic is modulo 2^WIDTH. Sub is a + ~b + 1.
- Both operands zero: result 0; carry_out = mode; overflow 0.

Optional Feature:
- Macro SERIAL_ADD_SUB_ZERO_FLAG_EN.
- Defined:
  - Adds output port zero (1 bit, reset 0).
  - zero is an OR-accumulator of the sum bits during RUN. It registers 1 on the final RUN edge iff all WIDTH result bits are 0.
  - zero updates/holds with the other flags; reset mid-RUN clears it.
- Undefined: port and accumulator are absent; all other behaviour is identical.

Test Plan:
1. WIDTH=8: rst 2 cycles, then start, mode=0, a=0x3C, b=0x0F -> ready=0 for 8 cycles; done in cycle 9 after accept; result=0x4B, carry_out=0, overflow=0.
2. Add a=0xFF, b=0x01 -> result=0x00, carry_out=1, overflow=0 (zero=1 if enabled). Add a=0x7F, b=0x01 -> result=0x80, carry_out=0, overflow=1.
3. Sub a=0x05, b=0x07 -> result=0xFE, carry_out=0, overflow=0. Sub a=0x80, b=0x01 -> result=0x7F, carry_out=1, overflow=1.
4. Pulse start mid-RUN with a=0xAA, b=0x55 -> ignored; in-flight op (0x10+0x20) completes with 0x30. Then start held high in the DONE cycle with 0x01+0x01 -> second op accepted immediately; two separate 1-cycle done pulses, second result=0x02.
5. Assert rst for one cycle after 3 bits of 0x12+0x34 -> result=0, flags=0, busy=0, ready=1 next cycle, no done. A new op 0x12+0x34 afterwards gives 0x46.
6. Random sweep: 1000 random (a, b, mode) at WIDTH=8 and WIDTH=16 -> result/carry_out/overflow match the reference model; done exactly once per accepted start.
